// File: rtl/famicom_bus_pkg.sv
// Shared constants, phase helpers and request payload for the Famicom CPU bus master.
package famicom_bus_pkg;

    localparam int unsigned CLK_DIV_NTSC     = 12;
    localparam int unsigned CLK_DIV_PAL      = 16;
    localparam int unsigned CLK_DIV_DENDY    = 15;
    localparam int unsigned M2_LOW_DEF       = 5;
    localparam int unsigned ROMSEL_DELAY_DEF = 1;

    // Phase indices of the NTSC default timing
    localparam int unsigned PH_M2_RISE = M2_LOW_DEF;
    localparam int unsigned PH_ROMSEL  = M2_LOW_DEF + ROMSEL_DELAY_DEF;
    localparam int unsigned PH_SAMPLE  = CLK_DIV_NTSC - 1;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned CPU_ADDR_W = 15;
    localparam int unsigned DATA_W     = 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic int unsigned ph_romsel(input int unsigned m2_low, input int unsigned dly);
        return m2_low + dly;
    endfunction

endpackage

// File: rtl/famicom_cpu_bus_master_if.sv
// Host request port, cartridge CPU bus pins and IRQ line of the bus master.
interface famicom_cpu_bus_master_if;
    import famicom_bus_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  m2;
    logic                  romsel;
    logic                  cpu_rw;
    logic [CPU_ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_data_out;
    logic                  cpu_data_oe;
    logic [DATA_W-1:0]     cpu_data_in;
    logic                  irq_n;
    logic                  irq;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, cpu_data_in, irq_n,
        output req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
               cpu_data_out, cpu_data_oe, irq
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, cpu_data_in, irq_n,
        input  req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
               cpu_data_out, cpu_data_oe, irq
    );

endinterface

// File: rtl/famicom_m2_phase_gen.sv
// Free-running M2 phase counter with registered M2 and per-phase strobes.
module famicom_m2_phase_gen
    import famicom_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_NTSC,
    parameter int unsigned M2_LOW       = M2_LOW_DEF,
    parameter int unsigned ROMSEL_DELAY = ROMSEL_DELAY_DEF,
    parameter int unsigned PH_W         = $clog2(CLK_DIV)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic [PH_W-1:0] o_ph,
    output logic            o_m2,
    output logic            o_ph0_c,
    output logic            o_m2_rise_c,
    output logic            o_romsel_c,
    output logic            o_sample_c
);

    localparam int unsigned PH_RISE = M2_LOW;
    localparam int unsigned PH_RSEL = ph_romsel(M2_LOW, ROMSEL_DELAY);
    localparam int unsigned PH_LAST = CLK_DIV - 1;

    if (M2_LOW < 1 || M2_LOW + ROMSEL_DELAY + 2 > CLK_DIV) begin : g_param_err
        $error("famicom_m2_phase_gen: illegal M2_LOW/ROMSEL_DELAY/CLK_DIV combination");
    end

    logic [PH_W-1:0] r_ph;
    logic            r_m2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ph <= '0;
            r_m2 <= 1'b0;
        end else begin
            r_ph <= (r_ph == PH_W'(PH_LAST)) ? '0 : r_ph + PH_W'(1);
            r_m2 <= (r_ph >= PH_W'(PH_RISE));
        end
    end

    assign o_ph        = r_ph;
    assign o_m2        = r_m2;
    assign o_ph0_c     = (r_ph == '0);
    assign o_m2_rise_c = (r_ph == PH_W'(PH_RISE));
    assign o_romsel_c  = (r_ph == PH_W'(PH_RSEL));
    assign o_sample_c  = (r_ph == PH_W'(PH_LAST));

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// Initiator of 2A03-style cartridge bus cycles: request latch, bus pin registers,
// read capture and IRQ synchroniser around a free-running M2 phase generator.
module famicom_cpu_bus_master
    import famicom_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_NTSC,
    parameter int unsigned M2_LOW       = M2_LOW_DEF,
    parameter int unsigned ROMSEL_DELAY = ROMSEL_DELAY_DEF
) (
    input logic                      clk,
    input logic                      reset,
    famicom_cpu_bus_master_if.master bus
);

    localparam int unsigned PH_W = $clog2(CLK_DIV);

    logic [PH_W-1:0]       w_ph;
    logic                  w_m2;
    logic                  w_ph0;
    logic                  w_rise;
    logic                  w_romsel_pt;
    logic                  w_sample;

    bus_req_t              r_req;
    logic                  r_req_valid;
    logic                  r_cur_rd;
    logic                  r_cpu_rw;
    logic [CPU_ADDR_W-1:0] r_cpu_addr;
    logic                  r_a15;
    logic                  r_romsel;
    logic                  r_oe;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [1:0]            r_irq_sync;

    famicom_m2_phase_gen #(
        .CLK_DIV      (CLK_DIV),
        .M2_LOW       (M2_LOW),
        .ROMSEL_DELAY (ROMSEL_DELAY),
        .PH_W         (PH_W)
    ) u_phase (
        .i_clk       (clk),
        .i_reset     (reset),
        .o_ph        (w_ph),
        .o_m2        (w_m2),
        .o_ph0_c     (w_ph0),
        .o_m2_rise_c (w_rise),
        .o_romsel_c  (w_romsel_pt),
        .o_sample_c  (w_sample)
    );

    // Request taken at the last phase drives the whole following period; r_cur_rd
    // remembers whether the period now ending was a read so its data is returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req       <= '0;
            r_req_valid <= 1'b0;
            r_cur_rd    <= 1'b0;
            r_cpu_rw    <= 1'b1;
            r_cpu_addr  <= '0;
            r_a15       <= 1'b0;
            r_romsel    <= 1'b1;
            r_oe        <= 1'b0;
            r_dout      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_irq_sync  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_irq_sync  <= {r_irq_sync[0], ~bus.irq_n};

            if (w_sample) begin
                r_req_valid <= bus.req_valid;
                if (bus.req_valid) begin
                    r_req <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
                end
            end

            if (w_ph0) begin
                r_romsel <= 1'b1;
                if (r_cur_rd) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= bus.cpu_data_in;
                end
                r_cur_rd <= r_req_valid & ~r_req.write;
                r_cpu_rw <= ~(r_req_valid & r_req.write);
                if (r_req_valid) begin
                    r_cpu_addr <= r_req.addr[CPU_ADDR_W-1:0];
                    r_a15      <= r_req.addr[ADDR_W-1];
                end
            end

            if (w_romsel_pt) begin
                r_romsel <= ~r_a15;
            end

            // Write data is held one clock past the M2 fall unless another write follows
            if (w_ph == PH_W'(1) && r_cpu_rw) begin
                r_oe <= 1'b0;
            end
            if (w_rise && !r_cpu_rw) begin
                r_oe   <= 1'b1;
                r_dout <= r_req.wdata;
            end
        end
    end

    assign bus.req_ready    = ~reset & w_sample;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.m2           = w_m2;
    assign bus.romsel       = r_romsel;
    assign bus.cpu_rw       = r_cpu_rw;
    assign bus.cpu_addr     = r_cpu_addr;
    assign bus.cpu_data_out = r_dout;
    assign bus.cpu_data_oe  = r_oe;
    assign bus.irq          = r_irq_sync[1];

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Randomised bench for famicom_cpu_bus_master against a period/phase reference model.
module tb_famicom_cpu_bus_master;
    import famicom_bus_pkg::*;

    localparam int unsigned CD = 12;
    localparam int unsigned ML = 5;
    localparam int unsigned RD = 1;

    typedef struct {
        bit         valid;
        bit         write;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    famicom_cpu_bus_master_if bus ();

    famicom_cpu_bus_master #(
        .CLK_DIV      (CD),
        .M2_LOW       (ML),
        .ROMSEL_DELAY (RD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    txn_t per [0:1023];
    txn_t dq [$];
    int   rd_times [$];
    int   k      = 0;
    int   gclk   = 0;
    bit   rand_on = 1'b0;
    bit   from_q  = 1'b0;
    logic [15:0] e_addr  = '0;
    logic [7:0]  e_dout  = '0;
    logic [7:0]  e_rdata = '0;
    logic        irqn_last = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // One clock: update the model on the edge, compare #1 later, then drive new inputs
    task automatic step();
        txn_t idle, cur, prv, t;
        bit   acc, e_rsp, cw, pw, e_oe, e_m2, e_romsel, e_ready;
        logic e_irq;
        int   p, pi, lat;
        idle  = '{valid: 1'b0, write: 1'b0, addr: 16'h0, wdata: 8'h0};
        t     = idle;
        acc   = 1'b0;
        e_rsp = 1'b0;
        e_irq = 1'b0;
        p     = 0;
        pi    = 0;
        @(posedge clk);
        gclk++;
        if (reset) begin
            k       = 0;
            e_addr  = '0;
            e_dout  = '0;
            e_rdata = '0;
            per[0]  = idle;
            rd_times.delete();
        end else begin
            e_irq = (k >= 1) ? ~irqn_last : 1'b0;
            k++;
            if (k % CD == 0) begin
                if (bus.req_valid) begin
                    t   = '{valid: 1'b1, write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
                    acc = 1'b1;
                end
                per[k / CD] = t;
                if (acc && !t.write) rd_times.push_back(gclk);
            end
            p  = (k - 1) % CD;
            pi = (k - 1) / CD;
            if (p == 0) begin
                if (pi >= 1 && per[pi-1].valid && !per[pi-1].write) begin
                    e_rsp   = 1'b1;
                    e_rdata = bus.cpu_data_in;
                end
                if (per[pi].valid) e_addr = per[pi].addr;
            end
            if (p == ML && per[pi].valid && per[pi].write) e_dout = per[pi].wdata;
        end
        irqn_last = bus.irq_n;
        #1;
        cur      = (k > 0) ? per[pi] : idle;
        prv      = (k > 0 && pi >= 1) ? per[pi-1] : idle;
        cw       = cur.valid && cur.write;
        pw       = prv.valid && prv.write;
        e_m2     = (k > 0) && (p >= ML);
        e_romsel = !((k > 0) && e_addr[15] && (p >= ML + RD));
        e_oe     = (k > 0) && ((cw && p >= ML) || (pw && (p == 0 || cw)));
        e_ready  = !reset && (k % CD == CD - 1);
        chk("m2",        32'(bus.m2),           32'(e_m2));
        chk("romsel",    32'(bus.romsel),       32'(e_romsel));
        chk("cpu_rw",    32'(bus.cpu_rw),       32'(!cw));
        chk("cpu_addr",  32'(bus.cpu_addr),     32'(e_addr[14:0]));
        chk("data_oe",   32'(bus.cpu_data_oe),  32'(e_oe));
        chk("data_out",  32'(bus.cpu_data_out), 32'(e_dout));
        chk("rsp_valid", 32'(bus.rsp_valid),    32'(e_rsp));
        chk("rsp_rdata", 32'(bus.rsp_rdata),    32'(e_rdata));
        chk("req_ready", 32'(bus.req_ready),    32'(e_ready));
        chk("irq",       32'(bus.irq),          32'(e_irq));
        if (bus.rsp_valid) begin
            if (rd_times.size() > 0) begin
                lat = gclk - rd_times.pop_front();
                chk("rd_latency", 32'(lat), 32'(CD + 1));
            end else begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
            end
        end
        if (acc && from_q && dq.size() > 0) void'(dq.pop_front());
        from_q = 1'b0;
        if (dq.size() > 0) begin
            bus.req_valid = 1'b1;
            bus.req_write = dq[0].write;
            bus.req_addr  = dq[0].addr;
            bus.req_wdata = dq[0].wdata;
            from_q        = 1'b1;
        end else if (rand_on) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = 16'($urandom);
            bus.req_wdata = 8'($urandom);
        end else begin
            bus.req_valid = 1'b0;
        end
        bus.cpu_data_in = 8'($urandom);
        bus.irq_n       = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        int  rises, highs, rlow, rsps, n;
        bit  prev_m2;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.cpu_data_in = '0;
        bus.irq_n       = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Idle periods straight after reset
        rises = 0; highs = 0; rlow = 0; rsps = 0; prev_m2 = 1'b0;
        repeat (20 * CD) begin
            step();
            if (bus.m2 && !prev_m2) rises++;
            if (bus.m2) highs++;
            if (!bus.romsel) rlow++;
            if (bus.rsp_valid) rsps++;
            prev_m2 = bus.m2;
        end
        chk("idle_m2_rises",  32'(rises), 32'(20));
        chk("idle_m2_high",   32'(highs), 32'(20 * (CD - ML)));
        chk("idle_romsel_lo", 32'(rlow),  32'(0));
        chk("idle_rsp",       32'(rsps),  32'(0));

        // Directed read, ROM-less write and back-to-back mapper writes
        dq.push_back('{valid: 1'b1, write: 1'b0, addr: 16'h8123, wdata: 8'h00});
        dq.push_back('{valid: 1'b1, write: 1'b1, addr: 16'h6000, wdata: 8'h3C});
        dq.push_back('{valid: 1'b1, write: 1'b1, addr: 16'h8000, wdata: 8'h01});
        dq.push_back('{valid: 1'b1, write: 1'b1, addr: 16'hA000, wdata: 8'h02});
        repeat (8 * CD) step();
        chk("directed_drained", 32'(dq.size()), 32'(0));

        rand_on = 1'b1;
        repeat (150 * CD) step();
        rand_on = 1'b0;
        repeat (2 * CD) step();

        // Abort a write with reset at its phase 8
        dq.push_back('{valid: 1'b1, write: 1'b1, addr: 16'h8000, wdata: 8'h77});
        n = 0;
        while (!(k > 0 && (k - 1) % CD == 8 && per[(k - 1) / CD].valid && per[(k - 1) / CD].write)
               && n < 4 * CD) begin
            step();
            n++;
        end
        chk("rst_wait_ok", 32'(n < 4 * CD), 32'(1));
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n = 0;
        while (!bus.m2 && n < 20) begin
            step();
            n++;
        end
        chk("rst_first_m2_rise", 32'(n), 32'(ML + 1));

        rand_on = 1'b1;
        repeat (40 * CD) step();
        rand_on = 1'b0;
        repeat (3 * CD) step();
        chk("rd_pending", 32'(rd_times.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
